// File: rtl/tick_timer_pkg.sv
// Shared constants, types and helpers for the tick timer bank.
package tick_timer_pkg;

  // Legacy sample period of the fixed free-running counter this bank replaces.
  localparam int DEFAULT_SAMPLE_PERIOD = 999900;

  // Channel operating mode: periodic re-arms at terminal count, one-shot halts.
  typedef enum logic {
    TM_PERIODIC = 1'b0,
    TM_ONESHOT  = 1'b1
  } tick_mode_e;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int calc_ch_w(input int num_ch);
    if (num_ch <= 1) begin
      return 1;
    end
    return $clog2(num_ch);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One timer channel: programmable terminal count, periodic/one-shot mode,
// start/stop control and a registered one-cycle tick at terminal count.
module tick_channel
  import tick_timer_pkg::*;
#(
  parameter int          WIDTH        = 24,
  parameter int unsigned RESET_PERIOD = DEFAULT_SAMPLE_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(RESET_PERIOD);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  tick_mode_e       mode_q, mode_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;
  logic             terminal;

  // >= rather than == so a period lowered below the current count wraps on
  // the very next step instead of running all the way round WIDTH bits.
  assign terminal = (count_q >= period_q);

  // Configuration capture; values written here are used from the next cycle.
  always_comb begin
    period_d = period_q;
    mode_d   = mode_q;
    if (cfg_we) begin
      period_d = cfg_period;
      mode_d   = cfg_oneshot ? TM_ONESHOT : TM_PERIODIC;
    end
  end

  // Count/run/tick next state: stop beats start, start beats a terminal step.
  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    tick_d    = 1'b0;
    if (stop) begin
      running_d = 1'b0;
    end else if (start) begin
      count_d   = '0;
      running_d = 1'b1;
    end else if (step && running_q) begin
      if (terminal) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (mode_q == TM_ONESHOT) begin
          running_d = 1'b0;
        end
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  // State registers; reset restores the legacy free-running configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      period_q  <= RST_PERIOD;
      mode_q    <= TM_PERIODIC;
      running_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      running_q <= running_d;
      tick_q    <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign count   = count_q;

endmodule

// File: rtl/tick_timer_bank.sv
// Multi-channel programmable timebase: one shared prescaler driving NUM_CH
// independent tick channels, with a single configuration write port.
module tick_timer_bank
  import tick_timer_pkg::*;
#(
  parameter int          WIDTH        = 24,
  parameter int          NUM_CH       = 2,
  parameter int          PRESC_W      = 8,
  parameter int unsigned RESET_PERIOD = DEFAULT_SAMPLE_PERIOD,
  localparam int         CH_W         = calc_ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [WIDTH-1:0]        cfg_period,
  input  logic                    cfg_oneshot,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH*WIDTH-1:0] count
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               step;
  logic [NUM_CH-1:0]  cfg_hit;

  // >= lets a lowered prescale take effect at once without wrapping through.
  assign step = (presc_cnt_q >= prescale);

  // Prescaler next state: clear on step, otherwise advance.
  always_comb begin
    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    if (step) begin
      presc_cnt_d = '0;
    end
  end

  // Shared prescaler counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

  // Config decode: a select beyond NUM_CH-1 matches no channel and is dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign cfg_hit[gi] = cfg_we && (cfg_ch == CH_W'(gi));

    tick_channel #(
      .WIDTH       (WIDTH),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .start      (start[gi]),
      .stop       (stop[gi]),
      .cfg_we     (cfg_hit[gi]),
      .cfg_period (cfg_period),
      .cfg_oneshot(cfg_oneshot),
      .tick       (tick[gi]),
      .running    (running[gi]),
      .count      (count[gi*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_tick_timer_bank.sv
// Self-checking bench for tick_timer_bank: per-channel tick scoreboards hold
// the expected tick cycles; a monitor pops and compares them as ticks appear.
module tb_tick_timer_bank;

  localparam int WIDTH   = 24;
  localparam int NUM_CH  = 3;
  localparam int PRESC_W = 8;
  localparam int RST_P   = 9;
  localparam int CH_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [PRESC_W-1:0]      prescale;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [WIDTH-1:0]        cfg_period;
  logic                    cfg_oneshot;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH*WIDTH-1:0] count;

  int                tests_run    = 0;
  int                tests_failed = 0;
  int                cyc;
  logic [NUM_CH-1:0] mon_en = '0;
  int                exp_q [NUM_CH][$];

  tick_timer_bank #(
    .WIDTH       (WIDTH),
    .NUM_CH      (NUM_CH),
    .PRESC_W     (PRESC_W),
    .RESET_PERIOD(RST_P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .running    (running),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Bench cycle counter: cyc == n at the falling edge after the n-th rising
  // edge following reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [WIDTH-1:0] cnt_of(input int ch);
    return count[ch*WIDTH +: WIDTH];
  endfunction

  // Tick monitor: each observed tick must match the head of its channel queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (mon_en[ch] && tick[ch]) begin
          tests_run++;
          if (exp_q[ch].size() == 0) begin
            tests_failed++;
            $display("FAIL tick_unexpected ch%0d: tick seen at cyc %0d, none expected", ch, cyc);
          end else begin
            int e;
            e = exp_q[ch].pop_front();
            if (cyc !== e) begin
              tests_failed++;
              $display("FAIL tick_time ch%0d: tick at cyc %0d, expected cyc %0d", ch, cyc, e);
            end else begin
              $display("[TB] ch%0d tick at cyc %0d", ch, cyc);
            end
          end
          tests_run++;
          if (cnt_of(ch) !== '0) begin
            tests_failed++;
            $display("FAIL tick_count ch%0d: count %0d during tick, expected 0", ch, cnt_of(ch));
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic reset_dut(input logic [PRESC_W-1:0] p);
    mon_en = '0;
    for (int ch = 0; ch < NUM_CH; ch++) exp_q[ch].delete();
    @(negedge clk);
    rst = 1'b1;
    prescale = p; cfg_we = 1'b0; start = '0; stop = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int per, input logic os);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_period = WIDTH'(per); cfg_oneshot = os;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp);
    start = st; stop = sp;
    @(negedge clk);
    start = '0; stop = '0;
  endtask

  task automatic check_drained(input string name);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      tests_run++;
      if (exp_q[ch].size() != 0) begin
        tests_failed++;
        $display("FAIL %s_missing ch%0d: %0d expected ticks not seen, next at cyc %0d",
                 name, ch, exp_q[ch].size(), exp_q[ch][0]);
      end
      exp_q[ch].delete();
    end
    mon_en = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (count !== '0) begin
      tests_failed++; $display("FAIL reset_count: count %h, expected 0", count);
    end
    tests_run++;
    if (tick !== '0) begin
      tests_failed++; $display("FAIL reset_tick: tick %b, expected 0", tick);
    end
    tests_run++;
    if (running !== '1) begin
      tests_failed++; $display("FAIL reset_running: running %b, expected all 1", running);
    end
  endtask

  // Default configuration: every channel counts 0..9 with prescale 0.
  task automatic test_free_run();
    reset_dut(0);
    mon_en = '1;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int t = 10; t <= 30; t += 10) exp_q[ch].push_back(t);
    while (cyc < 30) begin
      @(negedge clk);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        tests_run++;
        if (cnt_of(ch) !== WIDTH'(cyc % 10)) begin
          tests_failed++;
          $display("FAIL free_count ch%0d cyc %0d: count %0d, expected %0d", ch, cyc, cnt_of(ch), cyc % 10);
        end
      end
    end
    wait_cyc(32);
    check_drained("free_run");
  endtask

  // prescale 2: ch0 period 3 steps every 3 clks, ticks every 12.
  task automatic test_prescale();
    reset_dut(2);
    cfg_write(0, 3, 1'b0);
    mon_en[0] = 1'b1;
    for (int t = 12; t <= 36; t += 12) exp_q[0].push_back(t);
    while (cyc < 38) begin
      @(negedge clk);
      tests_run++;
      if (cnt_of(0) !== WIDTH'((cyc / 3) % 4)) begin
        tests_failed++;
        $display("FAIL presc_count cyc %0d: count %0d, expected %0d", cyc, cnt_of(0), (cyc / 3) % 4);
      end
    end
    check_drained("prescale");
  endtask

  // One-shot ch1 period 5, started on a step edge: single tick 18 clks later.
  task automatic test_oneshot();
    reset_dut(2);
    cfg_write(1, 5, 1'b1);
    @(negedge clk);
    pulse(3'b010, 3'b000);
    mon_en[1] = 1'b1;
    exp_q[1].push_back(21);
    while (cyc < 45) begin
      @(negedge clk);
      tests_run++;
      if (running[1] !== (cyc < 21)) begin
        tests_failed++;
        $display("FAIL oneshot_running cyc %0d: running %b, expected %b", cyc, running[1], cyc < 21);
      end
      tests_run++;
      if (cnt_of(1) !== WIDTH'((cyc < 21) ? (cyc - 3) / 3 : 0)) begin
        tests_failed++;
        $display("FAIL oneshot_count cyc %0d: count %0d, expected %0d", cyc, cnt_of(1),
                 (cyc < 21) ? (cyc - 3) / 3 : 0);
      end
    end
    check_drained("oneshot");
  endtask

  // Simultaneous start+stop halts; a later start alone restarts from 0.
  task automatic test_start_stop();
    reset_dut(0);
    mon_en[0] = 1'b1;
    wait_cyc(4);
    tests_run++;
    if (cnt_of(0) !== WIDTH'(4)) begin
      tests_failed++; $display("FAIL ss_pre_count: count %0d, expected 4", cnt_of(0));
    end
    pulse(3'b001, 3'b001);
    repeat (3) begin
      tests_run++;
      if (running[0] !== 1'b0 || cnt_of(0) !== WIDTH'(4)) begin
        tests_failed++;
        $display("FAIL ss_halt cyc %0d: running %b count %0d, expected 0 and 4", cyc, running[0], cnt_of(0));
      end
      @(negedge clk);
    end
    pulse(3'b001, 3'b000);
    tests_run++;
    if (running[0] !== 1'b1 || cnt_of(0) !== '0) begin
      tests_failed++;
      $display("FAIL ss_restart cyc %0d: running %b count %0d, expected 1 and 0", cyc, running[0], cnt_of(0));
    end
    @(negedge clk);
    tests_run++;
    if (cnt_of(0) !== WIDTH'(1)) begin
      tests_failed++; $display("FAIL ss_resume: count %0d, expected 1", cnt_of(0));
    end
    tests_run++;
    if (cnt_of(1) !== WIDTH'(cyc % 10)) begin
      tests_failed++; $display("FAIL ss_other_ch: ch1 count %0d, expected %0d", cnt_of(1), cyc % 10);
    end
    check_drained("start_stop");
  endtask

  // Lowering the period below count wraps on the next step; bad cfg_ch ignored.
  task automatic test_cfg_rewrite();
    reset_dut(0);
    mon_en = '1;
    for (int t = 9; t <= 41; t += 4) exp_q[0].push_back(t);
    for (int ch = 1; ch < NUM_CH; ch++)
      for (int t = 10; t <= 40; t += 10) exp_q[ch].push_back(t);
    wait_cyc(7);
    tests_run++;
    if (cnt_of(0) !== WIDTH'(7)) begin
      tests_failed++; $display("FAIL cfg_pre_count: count %0d, expected 7", cnt_of(0));
    end
    cfg_write(0, 3, 1'b0);
    tests_run++;
    if (cnt_of(0) !== WIDTH'(8)) begin
      tests_failed++; $display("FAIL cfg_count_kept: count %0d, expected 8", cnt_of(0));
    end
    wait_cyc(21);
    cfg_write(NUM_CH, 1, 1'b1);
    wait_cyc(43);
    tests_run++;
    if (running !== '1) begin
      tests_failed++; $display("FAIL cfg_bad_ch_running: running %b, expected all 1", running);
    end
    check_drained("cfg_rewrite");
  endtask

  // Reset asserted mid-cycle clears outputs immediately and restores defaults.
  task automatic test_async_reset();
    reset_dut(0);
    cfg_write(0, 2, 1'b1);
    cfg_write(2, 6, 1'b0);
    wait_cyc(10);
    tests_run++;
    if (tick !== 3'b010 || running !== 3'b110 || cnt_of(2) !== WIDTH'(3)) begin
      tests_failed++;
      $display("FAIL arst_pre: tick %b running %b ch2 count %0d, expected 010 110 3", tick, running, cnt_of(2));
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (count !== '0 || tick !== '0 || running !== '1) begin
      tests_failed++;
      $display("FAIL arst_immediate: count %h tick %b running %b, expected 0 0 111", count, tick, running);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = '1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_q[ch].push_back(10);
      exp_q[ch].push_back(20);
    end
    wait_cyc(22);
    tests_run++;
    if (running !== '1) begin
      tests_failed++; $display("FAIL arst_defaults_running: running %b, expected all 1", running);
    end
    check_drained("async_reset");
  endtask

  initial begin
    rst = 1'b1; prescale = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    cfg_oneshot = 1'b0; start = '0; stop = '0;
    test_reset();
    test_free_run();
    test_prescale();
    test_oneshot();
    test_start_stop();
    test_cfg_rewrite();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
